decode_in_txn_driver: RTL



---
 rtl/decode_in_drv_pkg.sv | 31 +++
 rtl/decode_in_txn_fifo.sv | 70 +++++++
 rtl/decode_in_txn_driver.sv | 214 +++++++++++++++++++++
 3 files changed

// File: rtl/decode_in_drv_pkg.sv
// -----------------------------------------------------------------------------
// decode_in_drv_pkg
//   Shared types for the decode-stage input transaction driver.
//   - drv_state_t : issue FSM states (IDLE / ISSUE / GAP)
//   - txn_t       : one buffered transaction {instr, npc, gap} at the default
//                   widths (16/16/4), handy for models and scoreboards
//   - txn_bits()  : packed width of a transaction for a given parameter set
// -----------------------------------------------------------------------------
package decode_in_drv_pkg;

  localparam int DATA_W_DEF = 16;
  localparam int PC_W_DEF   = 16;
  localparam int GAP_W_DEF  = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_GAP   = 2'd2
  } drv_state_t;

  typedef struct packed {
    logic [DATA_W_DEF-1:0] instr;
    logic [PC_W_DEF-1:0]   npc;
    logic [GAP_W_DEF-1:0]  gap;
  } txn_t;

  function automatic int txn_bits(input int data_w, input int pc_w, input int gap_w);
    return data_w + pc_w + gap_w;
  endfunction

endpackage

// File: rtl/decode_in_txn_fifo.sv
// -----------------------------------------------------------------------------
// decode_in_txn_fifo
//   Synchronous FIFO holding packed transactions for the decode input driver.
//   Pointers carry one extra wrap bit so full and empty are told apart without
//   a separate counter; count is the pointer difference.
//
//   Ports:
//     clk    in   clock, all logic on posedge
//     rst    in   synchronous active-high reset (empties the FIFO)
//     clr    in   synchronous clear (flush), same effect as rst
//     push   in   write din at the tail (ignored when full)
//     din    in   W-bit entry to write
//     pop    in   advance the head (ignored when empty)
//     head   out  entry at the head, valid whenever !empty
//     full   out  DEPTH entries held
//     empty  out  no entries held
//     count  out  number of entries held (0..DEPTH)
// -----------------------------------------------------------------------------
module decode_in_txn_fifo #(
  parameter int W     = 36,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clr,
  input  logic                     push,
  input  logic [W-1:0]             din,
  input  logic                     pop,
  output logic [W-1:0]             head,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] mem [DEPTH];
  logic [AW:0]  wr_ptr;
  logic [AW:0]  rd_ptr;
  logic         push_ok;
  logic         pop_ok;

  // Guard against misuse: never write past full or read past empty.
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  // Storage needs no reset: an entry is only read after it has been written.
  always_ff @(posedge clk) begin
    if (push_ok && !rst && !clr) begin
      mem[wr_ptr[AW-1:0]] <= din;
    end
  end

  assign head  = mem[rd_ptr[AW-1:0]];
  assign count = wr_ptr - rd_ptr;
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                 (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

endmodule

// File: rtl/decode_in_txn_driver.sv
// -----------------------------------------------------------------------------
// decode_in_txn_driver
//   Stimulus engine for the decode-stage input bus. Transactions
//   {instr, npc, gap} are accepted over a valid/ready port into a DEPTH-entry
//   FIFO and then driven onto enable_decode/dout/npc_in one per cycle, with a
//   per-transaction idle gap, plus pause and flush controls.
//
//   Ports:
//     decode_clock          in   sole clock, posedge
//     decode_reset          in   synchronous active-high reset
//     txn_valid/txn_ready   in/out  transaction handshake
//     txn_instr/npc/gap     in   transaction payload
//     pause                 in   freeze issue and gap progress
//     flush                 in   drop buffered and in-flight transactions
//     decode_enable_decode  out  registered enable to the decode DUT
//     decode_dout           out  registered instruction
//     decode_npc_in         out  registered NPC
//     txn_done              out  pulse with every enable cycle
//     fifo_count            out  entries buffered
//     drv_busy              out  FSM not IDLE or FIFO non-empty
//     issued_cnt            out  transactions driven since reset/flush
//     drv_state             out  current FSM state (debug)
//
//   Handshake: a transaction transfers at a rising edge where txn_valid and
//   txn_ready are both high. txn_ready depends only on FIFO fullness, flush
//   and reset, never on txn_valid. The source may hold or change its offer
//   while txn_ready is low; nothing is captured then.
// -----------------------------------------------------------------------------
module decode_in_txn_driver
  import decode_in_drv_pkg::*;
#(
  parameter int DATA_W    = 16,
  parameter int PC_W      = 16,
  parameter int DEPTH     = 8,
  parameter int GAP_W     = 4,
  parameter bit HOLD_LAST = 1'b1
) (
  input  logic                       decode_clock,
  input  logic                       decode_reset,
  input  logic                       txn_valid,
  output logic                       txn_ready,
  input  logic [DATA_W-1:0]          txn_instr,
  input  logic [PC_W-1:0]            txn_npc,
  input  logic [GAP_W-1:0]           txn_gap,
  input  logic                       pause,
  input  logic                       flush,
  output logic                       decode_enable_decode,
  output logic [DATA_W-1:0]          decode_dout,
  output logic [PC_W-1:0]            decode_npc_in,
  output logic                       txn_done,
  output logic [$clog2(DEPTH+1)-1:0] fifo_count,
  output logic                       drv_busy,
  output logic [15:0]                issued_cnt,
  output logic [1:0]                 drv_state
);

  localparam int TXN_W = txn_bits(DATA_W, PC_W, GAP_W);
  localparam int CW    = $clog2(DEPTH+1);

  // ---------------------------------------------------------------------------
  // Transaction FIFO
  // ---------------------------------------------------------------------------
  logic             fifo_push;
  logic             fifo_pop;
  logic [TXN_W-1:0] fifo_din;
  logic [TXN_W-1:0] fifo_head;
  logic             fifo_full;
  logic             fifo_empty;
  logic [CW-1:0]    fifo_cnt;

  logic [DATA_W-1:0] head_instr;
  logic [PC_W-1:0]   head_npc;
  logic [GAP_W-1:0]  head_gap;

  // Flush and reset both hold ready low so no push can race the clear.
  assign txn_ready = !fifo_full && !flush && !decode_reset;
  assign fifo_push = txn_valid && txn_ready;
  assign fifo_din  = {txn_instr, txn_npc, txn_gap};

  assign head_instr = fifo_head[TXN_W-1 -: DATA_W];
  assign head_npc   = fifo_head[GAP_W +: PC_W];
  assign head_gap   = fifo_head[GAP_W-1:0];

  decode_in_txn_fifo #(
    .W     (TXN_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (decode_clock),
    .rst   (decode_reset),
    .clr   (flush),
    .push  (fifo_push),
    .din   (fifo_din),
    .pop   (fifo_pop),
    .head  (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_cnt)
  );

  // ---------------------------------------------------------------------------
  // Issue FSM
  // ---------------------------------------------------------------------------
  drv_state_t        state_q;
  drv_state_t        state_next;
  logic [GAP_W-1:0]  gap_cnt_q;   // idle cycles still owed while in GAP
  logic [GAP_W-1:0]  cur_gap_q;   // gap field of the transaction on the bus
  logic              enable_q;
  logic [DATA_W-1:0] dout_q;
  logic [PC_W-1:0]   npc_q;
  logic [15:0]       issued_q;

  // State register
  always_ff @(posedge decode_clock) begin
    if (decode_reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_next;
    end
  end

  // Next-state logic; fifo_pop is asserted exactly on edges that issue.
  always_comb begin
    state_next = state_q;
    fifo_pop   = 1'b0;
    if (decode_reset || flush) begin
      state_next = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (!pause && !fifo_empty) begin
            fifo_pop   = 1'b1;
            state_next = ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          // The enable cycle is never stretched: even under pause we leave.
          if (cur_gap_q != '0) begin
            state_next = ST_GAP;
          end else if (!pause && !fifo_empty) begin
            fifo_pop   = 1'b1;
            state_next = ST_ISSUE;
          end else begin
            state_next = ST_IDLE;
          end
        end
        ST_GAP: begin
          // The last owed idle cycle ends on the edge where the count hits 0.
          if (!pause && gap_cnt_q <= GAP_W'(1)) begin
            if (!fifo_empty) begin
              fifo_pop   = 1'b1;
              state_next = ST_ISSUE;
            end else begin
              state_next = ST_IDLE;
            end
          end
        end
        default: begin
          state_next = ST_IDLE;
        end
      endcase
    end
  end

  // Registered datapath: bus values, gap counter and issue counter.
  always_ff @(posedge decode_clock) begin
    if (decode_reset) begin
      enable_q  <= 1'b0;
      dout_q    <= '0;
      npc_q     <= '0;
      issued_q  <= '0;
      gap_cnt_q <= '0;
      cur_gap_q <= '0;
    end else begin
      enable_q <= (state_next == ST_ISSUE);

      if (flush) begin
        issued_q  <= '0;
        gap_cnt_q <= '0;
        cur_gap_q <= '0;
      end else begin
        if (fifo_pop) begin
          issued_q  <= issued_q + 16'd1;
          cur_gap_q <= head_gap;
        end
        if (state_q == ST_ISSUE && state_next == ST_GAP) begin
          gap_cnt_q <= cur_gap_q;
        end else if (state_q == ST_GAP && !pause && gap_cnt_q != '0) begin
          gap_cnt_q <= gap_cnt_q - GAP_W'(1);
        end
      end

      if (fifo_pop) begin
        dout_q <= head_instr;
        npc_q  <= head_npc;
      end else if (!HOLD_LAST) begin
        dout_q <= '0;
        npc_q  <= '0;
      end
    end
  end

  // Output logic
  always_comb begin
    decode_enable_decode = enable_q;
    txn_done             = enable_q;
    decode_dout          = dout_q;
    decode_npc_in        = npc_q;
    fifo_count           = fifo_cnt;
    issued_cnt           = issued_q;
    drv_busy             = (state_q != ST_IDLE) || !fifo_empty;
    drv_state            = state_q;
  end

endmodule
